// File: rtl/util_heartbeat_pkg.sv
// Shared definitions for the heartbeat generator: FSM encoding and the
// "zero means one" clamp used on the period and width inputs.
package util_heartbeat_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_WAIT  = 2'd2
  } hb_state_t;

  // Callers zero-extend into 64 bits and truncate the result back.
  function automatic logic [63:0] min1(input logic [63:0] v);
    return (v == 64'd0) ? 64'd1 : v;
  endfunction

endpackage

// File: rtl/util_heartbeat_gen.sv
// Periodic keep-alive pulse generator. The period is counted in external
// ticks, the pulse width in clk cycles, and extra beats can be requested
// through a force_req/force_ack handshake.
module util_heartbeat_gen
  import util_heartbeat_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int WID_W      = 16,
  parameter int FIRST_BEAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] period,
  input  logic [WID_W-1:0] width,
  input  logic             cnt_pulse,
  input  logic             force_req,
  output logic             force_ack,
  output logic             hb_out,
  output logic             hb_start,
  output logic [CNT_W-1:0] hb_count,
  output logic             busy
);

  hb_state_t        r_state, w_nxt_state;
  logic [CNT_W-1:0] r_tick,  w_nxt_tick;
  logic [WID_W-1:0] r_wcnt,  w_nxt_wcnt;
  logic [CNT_W-1:0] r_count, w_nxt_count;
  logic             r_hb,    w_nxt_hb;
  logic             r_start, w_nxt_start;
  logic             r_ack,   w_nxt_ack;
  logic             r_busy;
  logic             w_load;
  logic [CNT_W-1:0] w_period_c;
  logic [WID_W-1:0] w_width_c;

  assign w_period_c = CNT_W'(min1(64'(period)));
  assign w_width_c  = WID_W'(min1(64'(width)));

  // Next-state and datapath: r_wcnt holds the high cycles left after the
  // current one, so a pulse ends when it reads zero in PULSE.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_tick  = r_tick;
    w_nxt_wcnt  = r_wcnt;
    w_nxt_count = r_count;
    w_nxt_hb    = r_hb;
    w_nxt_start = 1'b0;
    w_nxt_ack   = 1'b0;
    w_load      = 1'b0;
    if (!en) begin
      w_nxt_state = ST_IDLE;
      w_nxt_tick  = '0;
      w_nxt_wcnt  = '0;
      w_nxt_count = '0;
      w_nxt_hb    = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (FIRST_BEAT != 0) begin
            w_load = 1'b1;
          end else begin
            w_nxt_state = ST_WAIT;
            w_nxt_tick  = w_period_c;
          end
        end
        ST_PULSE: begin
          if (cnt_pulse && (r_tick != '0)) w_nxt_tick = r_tick - CNT_W'(1);
          if (r_wcnt == '0) begin
            w_nxt_state = ST_WAIT;
            w_nxt_hb    = 1'b0;
          end else begin
            w_nxt_wcnt = r_wcnt - WID_W'(1);
          end
        end
        ST_WAIT: begin
          // Expiry and a forced request collapse into one beat; the
          // request is still acknowledged so it is not replayed.
          if ((r_tick == '0) || force_req) begin
            w_load    = 1'b1;
            w_nxt_ack = force_req;
          end else if (cnt_pulse) begin
            w_nxt_tick = r_tick - CNT_W'(1);
          end
        end
        default: w_nxt_state = ST_IDLE;
      endcase
      if (w_load) begin
        w_nxt_state = ST_PULSE;
        w_nxt_hb    = 1'b1;
        w_nxt_start = 1'b1;
        w_nxt_tick  = w_period_c;
        w_nxt_wcnt  = w_width_c - WID_W'(1);
        w_nxt_count = (r_count == '1) ? r_count : r_count + CNT_W'(1);
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_tick  <= '0;
      r_wcnt  <= '0;
      r_count <= '0;
      r_hb    <= 1'b0;
      r_start <= 1'b0;
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_tick  <= w_nxt_tick;
      r_wcnt  <= w_nxt_wcnt;
      r_count <= w_nxt_count;
      r_hb    <= w_nxt_hb;
      r_start <= w_nxt_start;
      r_ack   <= w_nxt_ack;
      r_busy  <= (w_nxt_state != ST_IDLE);
    end
  end

  assign force_ack = r_ack;
  assign hb_out    = r_hb;
  assign hb_start  = r_start;
  assign hb_count  = r_count;
  assign busy      = r_busy;

endmodule

// File: tb/tb_util_heartbeat_gen.sv
// Bench for util_heartbeat_gen: one instance per FIRST_BEAT setting driven by
// shared stimulus, each compared every cycle against a behavioural model.
module tb_util_heartbeat_gen;

  localparam int CW = 8;
  localparam int WW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic [CW-1:0] period = '0;
  logic [WW-1:0] width = '0;
  logic          cnt_pulse = 1'b0;
  logic [1:0]    fr = '0;

  logic [1:0]         ack, hb, st, bz;
  logic [1:0][CW-1:0] cnt;
  logic [1:0][11:0]   obs;

  always #5 clk = ~clk;

  util_heartbeat_gen #(.CNT_W(CW), .WID_W(WW), .FIRST_BEAT(0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .period(period), .width(width),
    .cnt_pulse(cnt_pulse), .force_req(fr[0]), .force_ack(ack[0]),
    .hb_out(hb[0]), .hb_start(st[0]), .hb_count(cnt[0]), .busy(bz[0]));

  util_heartbeat_gen #(.CNT_W(CW), .WID_W(WW), .FIRST_BEAT(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .period(period), .width(width),
    .cnt_pulse(cnt_pulse), .force_req(fr[1]), .force_ack(ack[1]),
    .hb_out(hb[1]), .hb_start(st[1]), .hb_count(cnt[1]), .busy(bz[1]));

  assign obs[0] = {ack[0], hb[0], st[0], bz[0], cnt[0]};
  assign obs[1] = {ack[1], hb[1], st[1], bz[1], cnt[1]};

  int vecs = 0;
  int miss = 0;

  // Model: "active" = enabled and running, hi_left = high cycles still to
  // show, ticks = ticks until the next scheduled beat. Index = FIRST_BEAT.
  bit m_act [2];
  bit m_ack [2];
  bit m_st  [2];
  int m_hi  [2];
  int m_tk  [2];
  int m_cnt [2];

  function automatic int clamp1(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  function automatic logic [11:0] expv(input int f);
    logic [7:0] c;
    c = m_cnt[f][7:0];
    return {m_ack[f], (m_hi[f] > 0), m_st[f], m_act[f], c};
  endfunction

  task automatic beat(input int f);
    m_hi[f]  = clamp1(int'(width));
    m_tk[f]  = clamp1(int'(period));
    m_cnt[f] = (m_cnt[f] >= 255) ? 255 : m_cnt[f] + 1;
    m_st[f]  = 1'b1;
  endtask

  task automatic model_edge();
    for (int f = 0; f < 2; f++) begin
      m_ack[f] = 1'b0;
      m_st[f]  = 1'b0;
      if (rst || !en) begin
        m_act[f] = 1'b0; m_hi[f] = 0; m_tk[f] = 0; m_cnt[f] = 0;
      end else if (!m_act[f]) begin
        m_act[f] = 1'b1;
        if (f == 1) beat(f);
        else begin m_tk[f] = clamp1(int'(period)); m_hi[f] = 0; end
      end else if (m_hi[f] > 0) begin
        if (cnt_pulse && m_tk[f] > 0) m_tk[f]--;
        m_hi[f]--;
      end else if (m_tk[f] == 0 || fr[f]) begin
        m_ack[f] = fr[f];
        beat(f);
      end else if (cnt_pulse && m_tk[f] > 0) begin
        m_tk[f]--;
      end
    end
  endtask

  task automatic clk_step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  // Requester side of the handshake: drop the request once it is acked.
  task automatic hs_drop();
    for (int f = 0; f < 2; f++) if (m_ack[f]) fr[f] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; fr = 2'b11; cnt_pulse = 1'b1;
    for (int c = 0; c < 3; c++) begin
      clk_step();
      for (int f = 0; f < 2; f++) begin
        vecs++;
        if (obs[f] !== 12'h000) begin
          miss++;
          $display("FAIL reset c=%0d dut%0d got %h want %h", c, f, obs[f], 12'h000);
        end
      end
    end
    rst = 1'b0; en = 1'b0; fr = 2'b00; cnt_pulse = 1'b0;
    clk_step();
  endtask

  task automatic test_periodic();
    en = 1'b1; period = 8'd4; width = 6'd2;
    for (int c = 0; c < 60; c++) begin
      cnt_pulse = (c % 3 == 2);
      clk_step();
      for (int f = 0; f < 2; f++) begin
        vecs++;
        if (obs[f] !== expv(f)) begin
          miss++;
          $display("FAIL periodic c=%0d dut%0d got %h want %h", c, f, obs[f], expv(f));
        end
      end
    end
    // First beat appears one clk after en with FIRST_BEAT=1; a fixed
    // expectation independent of the model.
    en = 1'b0; clk_step(); en = 1'b1; clk_step();
    vecs++;
    if ({hb[1], st[1], cnt[1]} !== {1'b1, 1'b1, 8'd1}) begin
      miss++;
      $display("FAIL first_beat got %b%b/%0d want 11/1", hb[1], st[1], cnt[1]);
    end
  endtask

  task automatic test_fast();
    en = 1'b0; clk_step();
    en = 1'b1; period = 8'd0; width = 6'd0; cnt_pulse = 1'b1;
    for (int c = 0; c < 20; c++) begin
      clk_step();
      for (int f = 0; f < 2; f++) begin
        vecs++;
        if (obs[f] !== expv(f)) begin
          miss++;
          $display("FAIL fast c=%0d dut%0d got %h want %h", c, f, obs[f], expv(f));
        end
      end
      // 1,0,1,0 on the FIRST_BEAT instance: high on even cycles.
      vecs++;
      if (hb[1] !== ((c % 2) == 0)) begin
        miss++;
        $display("FAIL fast_pattern c=%0d got %b want %b", c, hb[1], (c % 2) == 0);
      end
    end
  endtask

  task automatic test_midpulse_expiry();
    en = 1'b0; clk_step();
    en = 1'b1; period = 8'd2; width = 6'd10; cnt_pulse = 1'b1;
    for (int c = 0; c < 40; c++) begin
      clk_step();
      for (int f = 0; f < 2; f++) begin
        vecs++;
        if (obs[f] !== expv(f)) begin
          miss++;
          $display("FAIL midpulse c=%0d dut%0d got %h want %h", c, f, obs[f], expv(f));
        end
      end
      // 10 high, 1 low, repeat.
      vecs++;
      if (hb[1] !== ((c % 11) != 10)) begin
        miss++;
        $display("FAIL midpulse_shape c=%0d got %b want %b", c, hb[1], (c % 11) != 10);
      end
    end
  endtask

  task automatic test_force();
    int raise_at [2];
    int raised   [2];
    raise_at[0] = -1; raise_at[1] = -1; raised[0] = 0; raised[1] = 0;
    en = 1'b0; cnt_pulse = 1'b0; fr = '0; clk_step();
    en = 1'b1; period = 8'd50; width = 6'd3;
    for (int c = 0; c < 40; c++) begin
      cnt_pulse = (c % 7 == 0);
      hs_drop();
      for (int f = 0; f < 2; f++) begin
        if (m_ack[f]) raise_at[f] = c + 1;
        if (c == 8 || (c == raise_at[f] && raised[f] < 2)) begin
          fr[f] = 1'b1;
          if (c != 8) raised[f]++;
        end
      end
      clk_step();
      for (int f = 0; f < 2; f++) begin
        vecs++;
        if (obs[f] !== expv(f)) begin
          miss++;
          $display("FAIL force c=%0d dut%0d got %h want %h", c, f, obs[f], expv(f));
        end
      end
    end
    fr = '0;
  endtask

  task automatic test_en_drop();
    en = 1'b0; clk_step();
    period = 8'd9; width = 6'd5; cnt_pulse = 1'b1;
    for (int c = 0; c < 14; c++) begin
      en = (c != 2);
      fr = (c >= 1 && c <= 2) ? 2'b11 : 2'b00;
      clk_step();
      for (int f = 0; f < 2; f++) begin
        vecs++;
        if (obs[f] !== expv(f)) begin
          miss++;
          $display("FAIL en_drop c=%0d dut%0d got %h want %h", c, f, obs[f], expv(f));
        end
      end
      if (c == 2) begin
        vecs++;
        if ({ack[1], hb[1], bz[1], cnt[1]} !== 11'd0) begin
          miss++;
          $display("FAIL en_drop_idle got %h want 0", {ack[1], hb[1], bz[1], cnt[1]});
        end
      end
    end
    fr = '0;
  endtask

  task automatic test_rst_wait();
    en = 1'b0; clk_step();
    en = 1'b1; period = 8'd50; width = 6'd1; cnt_pulse = 1'b0;
    for (int c = 0; c < 10; c++) begin
      rst = (c == 4);
      fr  = (c == 4 || c == 5) ? 2'b11 : 2'b00;
      clk_step();
      for (int f = 0; f < 2; f++) begin
        vecs++;
        if (obs[f] !== expv(f)) begin
          miss++;
          $display("FAIL rst_wait c=%0d dut%0d got %h want %h", c, f, obs[f], expv(f));
        end
      end
    end
    rst = 1'b0; fr = '0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(0, 39) == 0) en = ~en;
      else if (!en && $urandom_range(0, 3) == 0) en = 1'b1;
      if ($urandom_range(0, 9) == 0) begin
        period = 8'($urandom_range(0, 7));
        width  = 6'($urandom_range(0, 4));
      end
      cnt_pulse = ($urandom_range(0, 2) == 0);
      hs_drop();
      for (int f = 0; f < 2; f++)
        if (!fr[f] && !m_ack[f] && $urandom_range(0, 15) == 0) fr[f] = 1'b1;
      clk_step();
      for (int f = 0; f < 2; f++) begin
        vecs++;
        if (obs[f] !== expv(f)) begin
          miss++;
          $display("FAIL random c=%0d dut%0d got %h want %h", c, f, obs[f], expv(f));
        end
      end
    end
    fr = '0;
  endtask

  task automatic test_saturate();
    en = 1'b0; clk_step();
    en = 1'b1; period = 8'd0; width = 6'd0; cnt_pulse = 1'b1;
    for (int c = 0; c < 560; c++) begin
      clk_step();
      for (int f = 0; f < 2; f++) begin
        vecs++;
        if (obs[f] !== expv(f)) begin
          miss++;
          $display("FAIL saturate c=%0d dut%0d got %h want %h", c, f, obs[f], expv(f));
        end
      end
    end
    vecs++;
    if (cnt[1] !== 8'hFF) begin
      miss++;
      $display("FAIL saturate_final got %h want ff", cnt[1]);
    end
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_fast();
    test_midpulse_expiry();
    test_force();
    test_en_drop();
    test_rst_wait();
    test_random();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
